// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction-decode stage with register file (write-back
// bypass), in-flight destination scoreboard for RAW hazards, registered
// ID/EX outputs under a valid/ready handshake, flush and a stall counter.
// Optional macro ID_STAGE_FWD_EN: downstream forwarding exists, so only a
// load-use against the youngest scoreboard entry stalls.
module id_stage_pipe #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NREGS     = 16,
  parameter int unsigned HAZ_DEPTH = 3,
  parameter logic [DATA_W-1:0] SP_RESET = '1,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned REG_AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_inst,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mem_to_reg,
  output logic              out_reg_to_mem,
  output logic              out_alu_src,
  output logic              out_branch,
  output logic              out_call,
  output logic              out_ret,
  output logic              out_reg_wr,
  output logic [2:0]        out_alu_op,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_branch_cond,
  output logic [11:0]       out_call_tgt,
  output logic [DATA_W-1:0] out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [REG_AW-1:0] SP_ADDR = REG_AW'(NREGS - 1);

  logic [DATA_W-1:0] regs [NREGS];

  logic [HAZ_DEPTH-1:0] sb_v;
  logic [HAZ_DEPTH-1:0] sb_ld;
  logic [REG_AW-1:0]    sb_rd [HAZ_DEPTH];

  logic [3:0]        op;
  logic              d_m2r, d_r2m, d_src, d_br, d_call, d_ret, d_wr;
  logic [2:0]        d_alu_op;
  logic [REG_AW-1:0] d_rd, rs_a, rt_a;
  logic              use_rs, use_rt;
  logic [DATA_W-1:0] d_imm, rs_data, rt_data;
  logic              hazard, adv, accept;

  assign op = in_inst[15:12];

  // Opcode decode: control bits, source/destination addresses, immediate
  always_comb begin
    d_m2r    = 1'b0;
    d_r2m    = 1'b0;
    d_src    = 1'b0;
    d_br     = 1'b0;
    d_call   = 1'b0;
    d_ret    = 1'b0;
    d_wr     = 1'b0;
    d_alu_op = 3'b000;
    d_rd     = '0;
    rs_a     = REG_AW'(in_inst[7:4]);
    rt_a     = REG_AW'(in_inst[3:0]);
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    d_imm    = '0;
    if (!op[3]) begin
      d_alu_op = op[2:0];
      d_rd     = REG_AW'(in_inst[11:8]);
      use_rs   = 1'b1;
      use_rt   = 1'b1;
      d_wr     = 1'b1;
    end else begin
      case (op)
        4'h8: begin
          d_m2r  = 1'b1;
          d_src  = 1'b1;
          d_rd   = REG_AW'(in_inst[11:8]);
          use_rs = 1'b1;
          d_imm  = {{(DATA_W-4){in_inst[3]}}, in_inst[3:0]};
          d_wr   = 1'b1;
        end
        4'h9: begin
          d_r2m  = 1'b1;
          d_src  = 1'b1;
          rt_a   = REG_AW'(in_inst[11:8]);
          use_rs = 1'b1;
          use_rt = 1'b1;
          d_imm  = {{(DATA_W-4){in_inst[3]}}, in_inst[3:0]};
        end
        4'hA: begin
          d_src  = 1'b1;
          d_rd   = REG_AW'(in_inst[11:8]);
          rs_a   = REG_AW'(in_inst[11:8]);
          use_rs = 1'b1;
          d_imm  = {{(DATA_W-8){in_inst[7]}}, in_inst[7:0]};
          d_wr   = 1'b1;
        end
        4'hB: begin
          d_br  = 1'b1;
          d_imm = {{(DATA_W-8){in_inst[7]}}, in_inst[7:0]};
        end
        4'hC: begin
          d_call = 1'b1;
          rs_a   = SP_ADDR;
          use_rs = 1'b1;
        end
        4'hD: begin
          d_ret  = 1'b1;
          rs_a   = SP_ADDR;
          use_rs = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register-file reads with same-cycle write-back bypass
  always_comb begin
    rs_data = (wb_en && wb_addr == rs_a) ? wb_data : regs[rs_a];
    rt_data = (wb_en && wb_addr == rt_a) ? wb_data : regs[rt_a];
  end

  // RAW hazard against in-flight destinations
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
`ifdef ID_STAGE_FWD_EN
      if (i == 0 && sb_v[i] && sb_ld[i] &&
          ((use_rs && sb_rd[i] == rs_a) || (use_rt && sb_rd[i] == rt_a)))
        hazard = in_valid;
`else
      if (sb_v[i] &&
          ((use_rs && sb_rd[i] == rs_a) || (use_rt && sb_rd[i] == rt_a)))
        hazard = in_valid;
`endif
    end
  end

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Register file: SP preset on reset, write on wb_en
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS - 1; i++) regs[i] <= '0;
      regs[NREGS-1] <= SP_RESET;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard: shift on pipeline advance, slot0 takes the issued writer
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      sb_v <= '0;
      if (!rst) begin
        sb_ld <= '0;
        for (int i = 0; i < HAZ_DEPTH; i++) sb_rd[i] <= '0;
      end
    end else if (adv) begin
      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        sb_v[i]  <= sb_v[i-1];
        sb_ld[i] <= sb_ld[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
      sb_v[0]  <= accept && d_wr;
      sb_ld[0] <= accept && d_m2r;
      sb_rd[0] <= d_rd;
    end
  end

  // Saturating hazard-stall counter
  always_ff @(posedge clk) begin
    if (!rst) stall_cnt <= '0;
    else if (hazard && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  // ID/EX output register: flush kills, bubble on no accept, hold on backpressure
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_mem_to_reg  <= 1'b0;
      out_reg_to_mem  <= 1'b0;
      out_alu_src     <= 1'b0;
      out_branch      <= 1'b0;
      out_call        <= 1'b0;
      out_ret         <= 1'b0;
      out_reg_wr      <= 1'b0;
      out_alu_op      <= '0;
      out_rd          <= '0;
      out_rs_data     <= '0;
      out_rt_data     <= '0;
      out_imm         <= '0;
      out_branch_cond <= '0;
      out_call_tgt    <= '0;
      out_pc          <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= accept;
      if (accept) begin
        out_mem_to_reg  <= d_m2r;
        out_reg_to_mem  <= d_r2m;
        out_alu_src     <= d_src;
        out_branch      <= d_br;
        out_call        <= d_call;
        out_ret         <= d_ret;
        out_reg_wr      <= d_wr;
        out_alu_op      <= d_alu_op;
        out_rd          <= d_rd;
        out_rs_data     <= rs_data;
        out_rt_data     <= rt_data;
        out_imm         <= d_imm;
        out_branch_cond <= in_inst[11:9];
        out_call_tgt    <= in_inst[11:0];
        out_pc          <= in_pc;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed instructions push expected
// payloads; a monitor pops and compares on each output transfer.
module tb_id_stage_pipe;

  typedef logic [92:0] pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, wb_en, flush, out_valid, out_ready;
  logic [15:0] in_inst, in_pc, wb_data;
  logic [3:0]  wb_addr, out_rd;
  logic        out_mem_to_reg, out_reg_to_mem, out_alu_src, out_branch;
  logic        out_call, out_ret, out_reg_wr;
  logic [2:0]  out_alu_op, out_branch_cond;
  logic [15:0] out_rs_data, out_rt_data, out_imm, out_pc;
  logic [11:0] out_call_tgt;
  logic [7:0]  stall_cnt;

  int   checks = 0;
  int   errors = 0;
  pkt_t q[$];

  id_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_to_mem(out_reg_to_mem), .out_alu_src(out_alu_src),
    .out_branch(out_branch), .out_call(out_call), .out_ret(out_ret),
    .out_reg_wr(out_reg_wr), .out_alu_op(out_alu_op), .out_rd(out_rd),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_branch_cond(out_branch_cond), .out_call_tgt(out_call_tgt),
    .out_pc(out_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ctrl = {mem_to_reg, reg_to_mem, alu_src, branch, call, ret, reg_wr, alu_op}
  function automatic pkt_t mk(input logic [9:0] ctrl, input logic [3:0] rd,
                              input logic [15:0] rs, input logic [15:0] rt,
                              input logic [15:0] imm, input logic [15:0] inst,
                              input logic [15:0] pc);
    return {ctrl, rd, rs, rt, imm, inst[11:9], inst[11:0], pc};
  endfunction

  function automatic pkt_t dut_pkt();
    return {out_mem_to_reg, out_reg_to_mem, out_alu_src, out_branch, out_call,
            out_ret, out_reg_wr, out_alu_op, out_rd, out_rs_data, out_rt_data,
            out_imm, out_branch_cond, out_call_tgt, out_pc};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction until accepted; report bubbles seen
  task automatic issue(input logic [15:0] inst, input logic [15:0] pc, input pkt_t exp,
                       input logic wbe, input logic [3:0] wba, input logic [15:0] wbd,
                       output int stalls);
    bit done = 0;
    stalls = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_inst = inst; in_pc = pc;
      wb_en = wbe; wb_addr = wba; wb_data = wbd;
      #1;
      if (in_ready) begin q.push_back(exp); done = 1; end
      else stalls++;
      @(posedge clk);
      #1 wb_en = 1'b0;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL issue_timeout: inst %h never accepted", inst);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: compare each transferred payload with the queue head
  always @(negedge clk) begin
    #2;
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h expected none", dut_pkt());
      end else begin
        check("payload", 96'(dut_pkt()), 96'(q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [9:0] C_ALU0 = 10'b0000001_000;
  localparam logic [9:0] C_ALU1 = 10'b0000001_001;
  localparam logic [9:0] C_LW   = 10'b1010001_000;
  localparam logic [9:0] C_SW   = 10'b0110000_000;
  localparam logic [9:0] C_ADDI = 10'b0010001_000;
  localparam logic [9:0] C_BR   = 10'b0001000_000;
  localparam logic [9:0] C_CALL = 10'b0000100_000;
  localparam logic [9:0] C_RET  = 10'b0000010_000;

`ifdef ID_STAGE_FWD_EN
  localparam int ALU_BUB = 0;
  localparam int LD_BUB  = 1;
`else
  localparam int ALU_BUB = 3;
  localparam int LD_BUB  = 3;
`endif

  initial begin
    int   s;
    pkt_t e;
    rst = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    out_ready = 1'b1; flush = 1'b1;
    // write-back attempt during reset must be ignored
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'hAAAA;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 96'(out_valid), 96'(0));
    check("reset_stall_cnt", 96'(stall_cnt), 96'(0));
    check("reset_payload", 96'(dut_pkt()), 96'(0));
    wb_en = 1'b0; flush = 1'b0; rst = 1'b1;
    #1 check("reset_in_ready", 96'(in_ready), 96'(1));
    @(posedge clk);

    // SP reset value and cleared R3
    issue(16'hC123, 16'h0100, mk(C_CALL, 4'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'hC123, 16'h0100), 0, 0, 0, s);
    issue(16'h1030, 16'h0102, mk(C_ALU1, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h1030, 16'h0102), 0, 0, 0, s);
    idle(4);

    // Write-back bypass on the read port
    issue(16'h0657, 16'h0104, mk(C_ALU0, 4'd6, 16'h1234, 16'h0000, 16'h0000, 16'h0657, 16'h0104), 1, 4'd5, 16'h1234, s);
    check("bypass_stalls", 96'(s), 96'(0));
    idle(4);

    // Non-writing ops back to back: SW, branch, ret
    issue(16'h9A31, 16'h0106, mk(C_SW, 4'd0, 16'h0000, 16'h0000, 16'h0001, 16'h9A31, 16'h0106), 0, 0, 0, s);
    issue(16'hB6FE, 16'h0108, mk(C_BR, 4'd0, 16'hFFFF, 16'h0000, 16'hFFFE, 16'hB6FE, 16'h0108), 0, 0, 0, s);
    issue(16'hD000, 16'h010A, mk(C_RET, 4'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'hD000, 16'h010A), 0, 0, 0, s);
    check("nonwriter_stalls", 96'(s), 96'(0));
    idle(4);

    // ALU RAW dependency
    issue(16'h0211, 16'h0110, mk(C_ALU0, 4'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0211, 16'h0110), 0, 0, 0, s);
    issue(16'h0325, 16'h0112, mk(C_ALU0, 4'd3, 16'h0000, 16'h1234, 16'h0000, 16'h0325, 16'h0112), 0, 0, 0, s);
    check("alu_raw_bubbles", 96'(s), 96'(ALU_BUB));
    #1 check("alu_raw_stall_cnt", 96'(stall_cnt), 96'(ALU_BUB));
    idle(4);

    // Load-use with negative immediate
    issue(16'h841F, 16'h0120, mk(C_LW, 4'd4, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h841F, 16'h0120), 0, 0, 0, s);
    issue(16'h0544, 16'h0122, mk(C_ALU0, 4'd5, 16'h0000, 16'h0000, 16'h0000, 16'h0544, 16'h0122), 0, 0, 0, s);
    check("load_use_bubbles", 96'(s), 96'(LD_BUB));
    #1 check("load_use_stall_cnt", 96'(stall_cnt), 96'(ALU_BUB + LD_BUB));
    idle(4);

    // Backpressure hold, then release
    @(negedge clk);
    out_ready = 1'b0;
    e = mk(C_ADDI, 4'd7, 16'h0000, 16'h0000, 16'hFF80, 16'hA780, 16'h0130);
    issue(16'hA780, 16'h0130, e, 0, 0, 0, s);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_inst = 16'hE000; in_pc = 16'h0132;
      #1;
      check("hold_in_ready", 96'(in_ready), 96'(0));
      check("hold_payload", 96'({out_valid, dut_pkt()}), 96'({1'b1, e}));
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("release_in_ready", 96'(in_ready), 96'(1));
    if (in_ready) q.push_back(mk(10'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'hE000, 16'h0132));
    @(posedge clk);
    idle(4);

    // Flush during a load-use stall
    issue(16'h8211, 16'h0140, mk(C_LW, 4'd2, 16'h0000, 16'h0000, 16'h0001, 16'h8211, 16'h0140), 0, 0, 0, s);
    @(negedge clk);
    in_valid = 1'b1; in_inst = 16'h0325; in_pc = 16'h0142;
    #1 check("stall_in_ready", 96'(in_ready), 96'(0));
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_in_ready", 96'(in_ready), 96'(0));
    @(posedge clk);
    #1 check("flush_out_valid", 96'(out_valid), 96'(0));
    flush = 1'b0;
    issue(16'h0322, 16'h0144, mk(C_ALU0, 4'd3, 16'h0000, 16'h0000, 16'h0000, 16'h0322, 16'h0144), 0, 0, 0, s);
    check("post_flush_stalls", 96'(s), 96'(0));
    idle(6);

    check("queue_drained", 96'(q.size()), 96'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
